// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing: pixel-rate enable from a clock divider, h/v counters, registered sync/bright/frame_tick.
// Sync, bright and frame_tick are loaded from next-state counters, so they never lag hCount/vCount; no backpressure.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_en,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_TICK   = 10'(V_SYNC + V_BP + V_ACT - 1);
  // 11-bit decode bounds so an end-of-active value of 1024 still compares correctly
  localparam logic [10:0]   H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0]   H_ACT_BEG  = 11'(H_SYNC + H_BP);
  localparam logic [10:0]   H_ACT_END  = 11'(H_SYNC + H_BP + H_ACT);
  localparam logic [10:0]   V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0]   V_ACT_BEG  = 11'(V_SYNC + V_BP);
  localparam logic [10:0]   V_ACT_END  = 11'(V_SYNC + V_BP + V_ACT);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be within 1..16");
    end
  endgenerate

  logic [DW-1:0] div;
  logic          h_last;
  logic          v_last;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic [10:0]   h_ext;
  logic [10:0]   v_ext;

  assign pixel_en = ~rst && (div == DIV_LAST);
  assign h_last   = (hCount == H_LAST);
  assign v_last   = (vCount == V_LAST);

  always_comb begin
    h_nxt = hCount;
    v_nxt = vCount;
    if (pixel_en) begin
      h_nxt = h_last ? 10'd0 : hCount + 10'd1;
      if (h_last) begin
        v_nxt = v_last ? 10'd0 : vCount + 10'd1;
      end
    end
  end

  assign h_ext = {1'b0, h_nxt};
  assign v_ext = {1'b0, v_nxt};

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div        <= (div == DIV_LAST) ? '0 : div + DW'(1);
      hCount     <= h_nxt;
      vCount     <= v_nxt;
      hSync      <= ~(h_ext < H_SYNC_END);
      vSync      <= ~(v_ext < V_SYNC_END);
      bright     <= (h_ext >= H_ACT_BEG) && (h_ext < H_ACT_END) &&
                    (v_ext >= V_ACT_BEG) && (v_ext < V_ACT_END);
      // Entry into the vertical front porch: last pixel of the last active line
      frame_tick <= pixel_en && h_last && (vCount == V_TICK);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: instance a uses the default 640x480 timing for reset and line checks,
// instance b uses a tiny 15x9 geometry with CLK_DIV=1 so whole frames fit in a short run.
module tb_vga_sync_gen;

  logic       clk;
  logic       rst_a, rst_b;
  logic       pixel_en_a, hSync_a, vSync_a, bright_a, frame_tick_a;
  logic [9:0] hCount_a, vCount_a;
  logic       pixel_en_b, hSync_b, vSync_b, bright_b, frame_tick_b;
  logic [9:0] hCount_b, vCount_b;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  vga_sync_gen dut_a (
    .clk(clk), .rst(rst_a), .pixel_en(pixel_en_a), .hSync(hSync_a), .vSync(vSync_a),
    .bright(bright_a), .hCount(hCount_a), .vCount(vCount_a), .frame_tick(frame_tick_a)
  );

  // H: sync 2, bp 3, act 8, fp 2 -> 15; V: sync 1, bp 2, act 4, fp 2 -> 9; active h 5..12, v 3..6
  vga_sync_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(2),
    .V_SYNC(1), .V_BP(2), .V_ACT(4), .V_FP(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pixel_en(pixel_en_b), .hSync(hSync_b), .vSync(vSync_b),
    .bright(bright_b), .hCount(hCount_b), .vCount(vCount_b), .frame_tick(frame_tick_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int probe(input int sel);
    case (sel)
      0:       return int'(hSync_a);
      1:       return int'(hCount_a);
      2:       return int'(vCount_a);
      4:       return int'(hCount_b);
      5:       return int'(vCount_b);
      6:       return int'(frame_tick_b);
      default: return -1;
    endcase
  endfunction

  // Advance on falling edges until the probed signal equals val, at most lim cycles.
  task automatic wait_until(input int sel, input int val, input int lim, input string tag,
                            output int n);
    n = 0;
    while (probe(sel) != val && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, int'(probe(sel) == val), 1);
  endtask

  initial begin
    int c, n, t0, t1, t2;
    int ticks, tick_at, bcnt, vs_lo, hs_lo, pe_lo;
    int first_h, first_v, last_h, last_v;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_hcount", hCount_a, 0);
    check("rst_vcount", vCount_a, 0);
    check("rst_hsync", hSync_a, 0);
    check("rst_vsync", vSync_a, 0);
    check("rst_bright", bright_a, 0);
    check("rst_tick", frame_tick_a, 0);
    check("rst_pe_a", pixel_en_a, 0);
    check("rst_pe_b_div1", pixel_en_b, 0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("pe_b_cycle1", pixel_en_b, 1);
    c = 1;
    while (!pixel_en_a && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("first_pe_cycle", c, 4);
    check("hcount_before_pe", hCount_a, 0);
    @(negedge clk);
    check("hcount_after_pe", hCount_a, 1);
    check("pe_one_clk", pixel_en_a, 0);

    // Line timing on default geometry
    wait_until(0, 1, 4000, "hsync_rise0", n);
    check("hcount_at_hsync_rise", hCount_a, 96);
    wait_until(0, 0, 4000, "hsync_fall1", n);
    t0 = cyc;
    check("line1_hcount", hCount_a, 0);
    check("line1_vcount", vCount_a, 1);
    check("line1_vsync_low", vSync_a, 0);
    wait_until(0, 1, 4000, "hsync_rise1", n);
    t1 = cyc;
    check("hsync_low_clk", t1 - t0, 384);
    wait_until(1, 799, 4000, "hcount_799", n);
    check("vcount_at_799", vCount_a, 1);
    wait_until(1, 0, 10, "hcount_wrap", n);
    t2 = cyc;
    check("line_period_clk", t2 - t0, 3200);
    check("wrap_vcount_inc", vCount_a, 2);
    check("line2_vsync_high", vSync_a, 1);
    check("line2_hsync_low", hSync_a, 0);
    check("line2_bright", bright_a, 0);

    // Mid-line reset while pixel_en is low
    wait_until(1, 5, 40, "hcount_5", n);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_a_hcount", hCount_a, 0);
    check("midrst_a_vcount", vCount_a, 0);
    check("midrst_a_pe", pixel_en_a, 0);
    rst_a = 1'b0;
    #1;
    c = 1;
    while (!pixel_en_a && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("midrst_a_first_pe", c, 4);

    // Whole-frame scan on the small geometry
    wait_until(6, 1, 300, "tick_b", n);
    check("tick_hcount", hCount_b, 0);
    check("tick_vcount", vCount_b, 7);
    @(negedge clk);
    check("tick_width", frame_tick_b, 0);
    ticks = 0; tick_at = -1; bcnt = 0; vs_lo = 0; hs_lo = 0; pe_lo = 0;
    first_h = -1; first_v = -1; last_h = -1; last_v = -1;
    for (int i = 0; i < 135; i++) begin
      if (frame_tick_b) begin
        ticks++;
        tick_at = i;
      end
      if (bright_b) begin
        bcnt++;
        if (first_h < 0) begin
          first_h = hCount_b;
          first_v = vCount_b;
        end
        last_h = hCount_b;
        last_v = vCount_b;
      end
      if (!vSync_b) vs_lo++;
      if (!hSync_b) hs_lo++;
      if (!pixel_en_b) pe_lo++;
      @(negedge clk);
    end
    check("ticks_per_frame", ticks, 1);
    check("tick_period_idx", tick_at, 134);
    check("bright_count", bcnt, 32);
    check("bright_first_h", first_h, 5);
    check("bright_first_v", first_v, 3);
    check("bright_last_h", last_h, 12);
    check("bright_last_v", last_v, 6);
    check("vsync_low_clk", vs_lo, 15);
    check("hsync_low_clk_frame", hs_lo, 18);
    check("pe_b_low_count", pe_lo, 0);

    // Mid-frame reset on the small geometry at (7,5)
    wait_until(5, 5, 300, "b_line5", n);
    wait_until(4, 7, 20, "b_col7", n);
    rst_b = 1'b1;
    @(negedge clk);
    check("midrst_b_hcount", hCount_b, 0);
    check("midrst_b_vcount", vCount_b, 0);
    check("midrst_b_hsync", hSync_b, 0);
    check("midrst_b_vsync", vSync_b, 0);
    check("midrst_b_bright", bright_b, 0);
    check("midrst_b_tick", frame_tick_b, 0);
    check("midrst_b_pe", pixel_en_b, 0);
    rst_b = 1'b0;
    #1;
    check("midrst_b_pe_rel", pixel_en_b, 1);
    @(negedge clk);
    check("midrst_b_h1", hCount_b, 1);
    check("midrst_b_v0", vCount_b, 0);
    wait_until(6, 1, 300, "tick_after_rst", n);
    check("tick_after_rst_clk", n, 104);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
